// File: rtl/sync_seq_gen_moore.sv
`default_nettype none
// ============================================================================
// Module  : sync_seq_gen_moore
// Brief   : Moore transmitter replaying a latched (a,b) symbol pattern reps+1
//           times with a one-cycle done pulse. Optional SEQ_GEN_GAP_EN macro
//           inserts one idle symbol between consecutive passes.
// Revision: 1.0 - initial release
// ============================================================================
module sync_seq_gen_moore #(
    parameter int DEPTH = 4,
    parameter int REP_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic [2*DEPTH-1:0]       pattern,
    input  logic [REP_W-1:0]         reps,
    output logic                     a,
    output logic                     b,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH)-1:0] sym_idx
);

    localparam int                 c_IDX_W = $clog2(DEPTH);
    localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [2*DEPTH-1:0]   r_pat, w_pat_nxt;
    logic [REP_W-1:0]     r_reps, w_reps_nxt;
    logic [REP_W-1:0]     r_rep_cnt, w_rep_cnt_nxt;
    logic [c_IDX_W-1:0]   r_idx, w_idx_nxt;
    logic [1:0]           w_syms [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_sym
        assign w_syms[k] = r_pat[2*k +: 2];
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pat_nxt     = r_pat;
        w_reps_nxt    = r_reps;
        w_rep_cnt_nxt = r_rep_cnt;
        w_idx_nxt     = r_idx;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_pat_nxt     = pattern;
                    w_reps_nxt    = reps;
                    w_rep_cnt_nxt = '0;
                    w_idx_nxt     = '0;
                    w_state_nxt   = S_EMIT;
                end
            end
            S_EMIT: begin
                // abort outranks the pass-boundary decision
                if (abort) begin
                    w_idx_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else if (r_idx != c_LAST) begin
                    w_idx_nxt = r_idx + 1'b1;
                end else if (r_rep_cnt != r_reps) begin
                    w_rep_cnt_nxt = r_rep_cnt + 1'b1;
                    w_idx_nxt     = '0;
`ifdef SEQ_GEN_GAP_EN
                    w_state_nxt   = S_GAP;
`else
                    w_state_nxt   = S_EMIT;
`endif
                end else begin
                    w_idx_nxt   = '0;
                    w_state_nxt = S_DONE;
                end
            end
`ifdef SEQ_GEN_GAP_EN
            S_GAP: begin
                w_idx_nxt   = '0;
                w_state_nxt = abort ? S_IDLE : S_EMIT;
            end
`endif
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_idx_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_pat     <= '0;
            r_reps    <= '0;
            r_rep_cnt <= '0;
            r_idx     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pat     <= w_pat_nxt;
            r_reps    <= w_reps_nxt;
            r_rep_cnt <= w_rep_cnt_nxt;
            r_idx     <= w_idx_nxt;
        end
    end

    // Outputs are registered decodes of the present state only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a       <= 1'b0;
            b       <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sym_idx <= '0;
        end else begin
            a       <= (r_state == S_EMIT) & w_syms[r_idx][1];
            b       <= (r_state == S_EMIT) & w_syms[r_idx][0];
            busy    <= (r_state == S_EMIT) | (r_state == S_GAP);
            done    <= (r_state == S_DONE);
            sym_idx <= (r_state == S_EMIT) ? r_idx : '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sync_seq_gen_moore.sv
`default_nettype none
// ============================================================================
// Module  : tb_sync_seq_gen_moore
// Brief   : Table vectors, directed corner sequences and a random run checked
//           against a queue-based model of the symbol stream.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sync_seq_gen_moore;

    localparam int DEPTH = 4;
    localparam int REP_W = 4;

    logic       clk = 1'b0;
    logic       rst_n, start, abort;
    logic [7:0] pattern;
    logic [3:0] reps;
    logic       a, b, busy, done;
    logic [1:0] sym_idx;

    always #5 clk = ~clk;

    sync_seq_gen_moore #(.DEPTH(DEPTH), .REP_W(REP_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .pattern(pattern), .reps(reps),
        .a(a), .b(b), .busy(busy), .done(done), .sym_idx(sym_idx)
    );

    typedef struct packed {
        logic       a;
        logic       b;
        logic       busy;
        logic       done;
        logic [1:0] idx;
    } elem_t;

    typedef struct {
        logic       start;
        logic [7:0] pattern;
        logic [3:0] reps;
        logic [5:0] exp;
    } vec_t;

    elem_t plan[$];
    elem_t exp_e;
    int    total = 0;
    int    bad   = 0;
    int    busy_cnt, done_cnt;

    // Expected output stream of one run, one element per clock
    function automatic void build(input logic [7:0] pat, input logic [3:0] r);
        for (int p = 0; p <= int'(r); p++) begin
`ifdef SEQ_GEN_GAP_EN
            if (p > 0) plan.push_back(elem_t'{1'b0, 1'b0, 1'b1, 1'b0, 2'd0});
`endif
            for (int k = 0; k < DEPTH; k++)
                plan.push_back(elem_t'{pat[2*k+1], pat[2*k], 1'b1, 1'b0, 2'(k)});
        end
        plan.push_back(elem_t'{1'b0, 1'b0, 1'b0, 1'b1, 2'd0});
    endfunction

    task automatic check(input string nm, input logic [5:0] got, input logic [5:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got {a,b,busy,done,idx}=%b expected=%b at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", nm, got, exp);
        end
    endtask

    task automatic tick(input string nm, input bit use_model);
        @(posedge clk);
        if (plan.size() == 0) begin
            exp_e = '0;
            if (start) build(pattern, reps);
        end else begin
            exp_e = plan.pop_front();
            if (exp_e.busy && abort) plan.delete();
        end
        @(negedge clk);
        if (busy) busy_cnt++;
        if (done) done_cnt++;
        if (use_model) check(nm, {a, b, busy, done, sym_idx}, exp_e);
    endtask

    task automatic flush(input string nm);
        int n;
        n = 0;
        while (plan.size() > 0 && n < 200) begin
            tick(nm, 1'b1);
            n++;
        end
        if (plan.size() > 0) check_int({nm, "_timeout"}, plan.size(), 0);
        tick(nm, 1'b1);
    endtask

    vec_t tbl[7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, 8'h66, 4'd0,  6'b00_0_0_00};
        tbl[1] = '{1'b0, 8'h66, 4'd0,  6'b10_1_0_00};
        tbl[2] = '{1'b0, 8'hFF, 4'd15, 6'b01_1_0_01};
        tbl[3] = '{1'b0, 8'hFF, 4'd15, 6'b10_1_0_10};
        tbl[4] = '{1'b0, 8'hFF, 4'd15, 6'b01_1_0_11};
        tbl[5] = '{1'b0, 8'hFF, 4'd15, 6'b00_0_1_00};
        tbl[6] = '{1'b0, 8'hFF, 4'd15, 6'b00_0_0_00};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; pattern = '0; reps = '0;
        busy_cnt = 0; done_cnt = 0;
        #1;
        check("reset_state", {a, b, busy, done, sym_idx}, 6'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick("post_reset", 1'b1);

        // single pass, fixed vectors
        for (int i = 0; i < 7; i++) begin
            start = tbl[i].start; pattern = tbl[i].pattern; reps = tbl[i].reps;
            tick("table", 1'b0);
            check($sformatf("table[%0d]", i), {a, b, busy, done, sym_idx}, tbl[i].exp);
        end

        // asynchronous reset in the middle of a run
        start = 1'b1; pattern = 8'h66; reps = 4'd3;
        tick("rst_run", 1'b1);
        start = 1'b0;
        repeat (3) tick("rst_run", 1'b1);
        #2 rst_n = 1'b0;
        #1 check("rst_mid_emit", {a, b, busy, done, sym_idx}, 6'b0);
        plan.delete();
        @(negedge clk);
        rst_n = 1'b1;
        tick("rst_idle", 1'b1);
        start = 1'b1; reps = 4'd0;
        tick("rst_restart", 1'b1);
        start = 1'b0;
        flush("rst_restart");

        // three passes: busy length and done count
        busy_cnt = 0; done_cnt = 0;
        start = 1'b1; pattern = 8'h66; reps = 4'd2;
        tick("reps2", 1'b1);
        start = 1'b0;
        flush("reps2");
`ifdef SEQ_GEN_GAP_EN
        check_int("reps2_busy_cycles", busy_cnt, 14);
`else
        check_int("reps2_busy_cycles", busy_cnt, 12);
`endif
        check_int("reps2_done_count", done_cnt, 1);

        // abort while the third symbol is being emitted
        busy_cnt = 0; done_cnt = 0;
        start = 1'b1; reps = 4'd1;
        tick("abort", 1'b1);
        start = 1'b0;
        repeat (2) tick("abort", 1'b1);
        abort = 1'b1;
        tick("abort_sym2", 1'b1);
        abort = 1'b0;
        tick("abort_after", 1'b1);
        check("abort_idle", {a, b, busy, done, sym_idx}, 6'b0);
        tick("abort_gap", 1'b1);
        start = 1'b1;
        tick("abort_restart", 1'b1);
        start = 1'b0;
        tick("abort_restart", 1'b1);
        check("abort_restart_idx0", {a, b, busy, done, sym_idx}, 6'b10_1_0_00);
        flush("abort_restart");
        check_int("abort_done_count", done_cnt, 1);

        // start held high, pattern changed mid-run
        busy_cnt = 0; done_cnt = 0;
        start = 1'b1; pattern = 8'h66; reps = 4'd1;
        repeat (3) tick("hold", 1'b1);
        pattern = 8'hFF;
        repeat (7) tick("hold", 1'b1);
        check_int("hold_first_done", done_cnt, 1);
        start = 1'b0;
        flush("hold");

        // sixteen passes, no counter overflow
        busy_cnt = 0; done_cnt = 0;
        start = 1'b1; pattern = 8'h66; reps = 4'hF;
        tick("reps15", 1'b1);
        start = 1'b0;
        flush("reps15");
`ifdef SEQ_GEN_GAP_EN
        check_int("reps15_busy_cycles", busy_cnt, 16 * DEPTH + 15);
`else
        check_int("reps15_busy_cycles", busy_cnt, 16 * DEPTH);
`endif
        check_int("reps15_done_count", done_cnt, 1);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            start   = ($urandom % 4) == 0;
            abort   = ($urandom % 20) == 0;
            pattern = 8'($urandom);
            reps    = (($urandom % 6) == 0) ? 4'($urandom) : 4'($urandom % 3);
            tick("random", 1'b1);
        end
        start = 1'b0; abort = 1'b0;
        flush("random_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
